matrix_result_reader: RTL and testbench

//  Consumer end of the matrix_multiplier result handshake (Out/out_ready/out_ack).

---
 rtl/matrix_result_reader.sv | 182 ++++++++++++++++++
 tb/tb_matrix_result_reader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_reader.sv
// rtl/matrix_result_reader.sv - captures one packed result matrix, four-phase acks it, streams elements row-major.
// Optional per-element NaN flag enabled by defining RESULT_NAN_FLAG_EN.
module matrix_result_reader #(
  parameter int NUM_ROWS   = 2,
  parameter int NUM_COLS   = 2,
  parameter int DATA_WIDTH = 32,
  localparam int N_ELEM    = NUM_ROWS * NUM_COLS,
  localparam int BUS_W     = N_ELEM * DATA_WIDTH,
  localparam int ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int COL_W     = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
  localparam int IDX_W     = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUS_W-1:0]      res_in,
  input  logic                  res_ready,
  output logic                  res_ack,
  output logic [DATA_WIDTH-1:0] elem_data,
  output logic [ROW_W-1:0]      elem_row,
  output logic [COL_W-1:0]      elem_col,
  output logic                  elem_valid,
  input  logic                  elem_ready,
  output logic                  elem_last,
  output logic                  elem_nan,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [BUS_W-1:0]      buf_q, buf_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  ack_q, ack_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [COL_W-1:0]      col_q, col_d;

  logic                  load_en;
  logic [BUS_W-1:0]      load_bus;
  logic [IDX_W-1:0]      load_idx;

  function automatic logic [DATA_WIDTH-1:0] pick_elem(input logic [BUS_W-1:0] bus,
                                                      input logic [IDX_W-1:0] i);
    pick_elem = '0;
    for (int k = 0; k < N_ELEM; k++) begin
      if (int'(i) == k) pick_elem = bus[k*DATA_WIDTH +: DATA_WIDTH];
    end
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [IDX_W-1:0] i);
    row_of = ROW_W'(int'(i) / NUM_COLS);
  endfunction

  function automatic logic [COL_W-1:0] col_of(input logic [IDX_W-1:0] i);
    col_of = COL_W'(int'(i) % NUM_COLS);
  endfunction

`ifdef RESULT_NAN_FLAG_EN
  logic nan_q, nan_d;

  function automatic logic is_nan(input logic [DATA_WIDTH-1:0] v);
    is_nan = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction
`endif

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    idx_d    = idx_q;
    ack_d    = ack_q;
    valid_d  = valid_q;
    last_d   = last_q;
    data_d   = data_q;
    row_d    = row_q;
    col_d    = col_q;
    load_en  = 1'b0;
    load_bus = buf_q;
    load_idx = idx_q;
`ifdef RESULT_NAN_FLAG_EN
    nan_d    = nan_q;
`endif

    // The ack releases the producer independently of how far the drain has got.
    if (ack_q && !res_ready) ack_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (res_ready) begin
          buf_d    = res_in;
          idx_d    = '0;
          ack_d    = 1'b1;
          valid_d  = 1'b1;
          state_d  = DRAIN;
          load_en  = 1'b1;
          load_bus = res_in;
          load_idx = '0;
        end
      end
      DRAIN: begin
        if (valid_q && elem_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = ack_d ? WAIT_REL : IDLE;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            load_en  = 1'b1;
            load_idx = idx_q + IDX_W'(1);
          end
        end
      end
      WAIT_REL: begin
        if (!ack_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load_en) begin
      data_d = pick_elem(load_bus, load_idx);
      row_d  = row_of(load_idx);
      col_d  = col_of(load_idx);
      last_d = (load_idx == IDX_W'(N_ELEM - 1));
`ifdef RESULT_NAN_FLAG_EN
      nan_d  = is_nan(pick_elem(load_bus, load_idx));
`endif
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

`ifdef RESULT_NAN_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) nan_q <= 1'b0;
    else     nan_q <= nan_d;
  end
  assign elem_nan = nan_q;
`else
  assign elem_nan = 1'b0;
`endif

  assign res_ack    = ack_q;
  assign elem_valid = valid_q;
  assign elem_last  = last_q;
  assign elem_data  = data_q;
  assign elem_row   = row_q;
  assign elem_col   = col_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_matrix_result_reader.sv
// tb/tb_matrix_result_reader.sv - directed and randomized checks of matrix_result_reader against a transaction model.
module tb_matrix_result_reader;
  localparam int NR = 2;
  localparam int NC = 2;
  localparam int DW = 32;
  localparam int NE = NR * NC;
  localparam int BW = NE * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] res_in;
  logic          res_ready;
  logic          res_ack;
  logic [DW-1:0] elem_data;
  logic [0:0]    elem_row;
  logic [0:0]    elem_col;
  logic          elem_valid;
  logic          elem_ready;
  logic          elem_last;
  logic          elem_nan;
  logic          busy;

  int n_cmp = 0;
  int n_mis = 0;

  // Transaction model: captured matrix, next element index, elements left, ack level.
  logic [BW-1:0] m_mat;
  int            m_idx;
  int            m_rem;
  bit            m_ack;
  int            n_xfer;

  matrix_result_reader #(.NUM_ROWS(NR), .NUM_COLS(NC), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .res_in(res_in), .res_ready(res_ready), .res_ack(res_ack),
    .elem_data(elem_data), .elem_row(elem_row), .elem_col(elem_col),
    .elem_valid(elem_valid), .elem_ready(elem_ready), .elem_last(elem_last),
    .elem_nan(elem_nan), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit exp_nan(input logic [31:0] v);
`ifdef RESULT_NAN_FLAG_EN
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] rand_elem();
    case ($urandom % 8)
      0:       return 32'h7FC00000 | ($urandom % 32'h003FFFFF);
      1:       return 32'h7F800000;
      2:       return 32'hFF800001;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [BW-1:0] rand_mat();
    logic [BW-1:0] m;
    for (int i = 0; i < NE; i++) m[i*DW +: DW] = rand_elem();
    return m;
  endfunction

  // Called at a falling edge: check outputs against the model, drive inputs, advance one cycle.
  task automatic cycle(input logic rr, input logic [BW-1:0] din, input logic er);
    logic [31:0] e;
    bit          idle;
    check_val("elem_valid", elem_valid, m_rem > 0);
    check_val("res_ack", res_ack, m_ack);
    check_val("busy", busy, (m_rem > 0) || m_ack);
    if (m_rem > 0) begin
      e = m_mat[m_idx*DW +: DW];
      check_val("elem_data", elem_data, e);
      check_val("elem_row", elem_row, m_idx / NC);
      check_val("elem_col", elem_col, m_idx % NC);
      check_val("elem_last", elem_last, m_idx == NE - 1);
      check_val("elem_nan", elem_nan, exp_nan(e));
    end
    res_ready  = rr;
    res_in     = din;
    elem_ready = er;
    idle = (m_rem == 0) && !m_ack;
    if (idle && rr) begin
      m_mat = din;
      m_idx = 0;
      m_rem = NE;
      m_ack = 1'b1;
    end else begin
      if (m_rem > 0 && er) begin
        m_idx++;
        m_rem--;
        n_xfer++;
      end
      if (m_ack && !rr) m_ack = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_outs"},
              {res_ack, elem_valid, elem_last, elem_nan, busy, elem_row, elem_col},
              7'd0);
    check_val({tag, "_data"}, elem_data, 32'd0);
  endtask

  logic [BW-1:0] t2;
  logic [BW-1:0] t6;
  int            x0;

  initial begin
    t2 = 128'h41B00000_41700000_41200000_40E00000;
    t6 = 128'h3F800000_7FC00000_7F800000_40000000;
    rst = 1'b1; res_ready = 1'b0; res_in = '0; elem_ready = 1'b0;
    m_mat = '0; m_idx = 0; m_rem = 0; m_ack = 1'b0; n_xfer = 0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Streaming with elem_ready tied high, then a late release.
    x0 = n_xfer;
    cycle(1'b1, t2, 1'b1);
    check_val("t2_first_valid", elem_valid, 1'b1);
    check_val("t2_first_data", elem_data, 32'h40E00000);
    for (int i = 0; i < 5; i++) cycle(1'b1, rand_mat(), 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, rand_mat(), 1'b1);
    check_val("t2_xfers", n_xfer - x0, 4);

    // Backpressure on element 1.
    x0 = n_xfer;
    cycle(1'b1, t2, 1'b1);
    cycle(1'b0, rand_mat(), 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, rand_mat(), 1'b0);
    check_val("t3_held_data", elem_data, 32'h41200000);
    for (int i = 0; i < 5; i++) cycle(1'b0, rand_mat(), 1'b1);
    check_val("t3_xfers", n_xfer - x0, 4);

    // res_ready held across a completed matrix: no second capture.
    x0 = n_xfer;
    cycle(1'b1, t2, 1'b1);
    for (int i = 0; i < 14; i++) cycle(1'b1, rand_mat(), 1'b1);
    check_val("t4_xfers", n_xfer - x0, 4);
    check_val("t4_wait_ack", res_ack, 1'b1);
    cycle(1'b0, rand_mat(), 1'b1);
    cycle(1'b0, rand_mat(), 1'b1);

    // Early release, then an immediate new request while still draining.
    x0 = n_xfer;
    cycle(1'b1, t2, 1'b1);
    cycle(1'b0, rand_mat(), 1'b1);
    for (int i = 0; i < 8; i++) cycle(1'b1, rand_mat(), 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, rand_mat(), 1'b1);
    check_val("t5_xfers", n_xfer - x0, 8);

    // NaN and infinity elements.
    cycle(1'b1, t6, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, rand_mat(), 1'b1);

    // Asynchronous reset in the middle of a drain.
    cycle(1'b1, t2, 1'b1);
    cycle(1'b0, rand_mat(), 1'b1);
    #2 rst = 1'b1;
    #1 check_all_zero("t1_async");
    m_rem = 0; m_idx = 0; m_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, rand_mat(), 1'b1);

    // Randomized producer and consumer behaviour.
    for (int i = 0; i < 3000; i++)
      cycle(($urandom % 3) != 0, rand_mat(), ($urandom % 4) != 0);
    for (int i = 0; i < 20; i++) cycle(1'b0, rand_mat(), 1'b1);
    check_val("final_idle_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
